// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions: forwarding select codes, divide FSM states, x0 index, source-match helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0  = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_LAST = 2'd2
    } div_state_t;

    // A producer matches a source only if it writes, is not x0, and names the same register.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs, input logic en);
        return en && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register indices/flags in, hold/flush/forward controls out.
// Latency: plain wires, no storage.
// Backpressure: none; master is the pipeline datapath, slave is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import core_pkg::*;

    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             ex_div;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             mem_redirect;

    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             div_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_regwrite, ex_memtoreg, ex_div,
        output mem_rd, mem_regwrite, mem_memtoreg,
        output wb_rd, wb_regwrite, mem_redirect,
        input  pc_hold, ifid_hold, idex_hold,
        input  ifid_flush, idex_flush, exmem_flush,
        input  fwd_a, fwd_b, div_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_regwrite, ex_memtoreg, ex_div,
        input  mem_rd, mem_regwrite, mem_memtoreg,
        input  wb_rd, wb_regwrite, mem_redirect,
        output pc_hold, ifid_hold, idex_hold,
        output ifid_flush, idex_flush, exmem_flush,
        output fwd_a, fwd_b, div_busy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Per-operand EX forwarding select: EX/MEM ALU result beats MEM/WB result beats register file.
// Latency: purely combinational.
// Backpressure: none.
module forward_sel
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       mem_memtoreg,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);

    // A load still in EX/MEM has no data yet, so only ALU producers there may forward.
    always_comb begin
        fwd = FWD_RF;
        if (src_match(mem_rd, rs, mem_regwrite && !mem_memtoreg)) begin
            fwd = FWD_MEM;
        end else if (src_match(wb_rd, rs, wb_regwrite)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipe: holds, bubbles, squashes and forwarding selects.
// Latency: controls are combinational in the current cycle; counters and rs copies update on the next edge.
// Backpressure: none accepted; the pipe obeys hold/flush every cycle with redirect > divide > load-use.
module pipeline_hazard_ctrl
    import core_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int CNT_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int               DCW       = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [DCW-1:0]   DIV_LOAD  = DCW'(DIV_LATENCY - 2);
    // With the minimum latency there are no wait cycles, so the divide goes straight to its last cycle.
    localparam div_state_t       DIV_FIRST = (DIV_LATENCY > 2) ? DIV_WAIT : DIV_LAST;

    div_state_t       state_q, state_d;
    logic [DCW-1:0]   cnt_q, cnt_d;
    logic [4:0]       ex_rs1, ex_rs2;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use;
    logic             pc_hold, ifid_hold, idex_hold;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic             div_busy;

    assign load_use = bus.ex_memtoreg &&
                      (src_match(bus.ex_rd, bus.id_rs1, bus.id_uses_rs1) ||
                       src_match(bus.ex_rd, bus.id_rs2, bus.id_uses_rs2));

    forward_sel u_fwd_a (
        .rs           (ex_rs1),
        .mem_rd       (bus.mem_rd),
        .mem_regwrite (bus.mem_regwrite),
        .mem_memtoreg (bus.mem_memtoreg),
        .wb_rd        (bus.wb_rd),
        .wb_regwrite  (bus.wb_regwrite),
        .fwd          (bus.fwd_a)
    );

    forward_sel u_fwd_b (
        .rs           (ex_rs2),
        .mem_rd       (bus.mem_rd),
        .mem_regwrite (bus.mem_regwrite),
        .mem_memtoreg (bus.mem_memtoreg),
        .wb_rd        (bus.wb_rd),
        .wb_regwrite  (bus.wb_regwrite),
        .fwd          (bus.fwd_b)
    );

    // Next state and stage controls: a redirect squashes everything and aborts any divide in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        div_busy    = 1'b0;
        if (bus.mem_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ex_div) begin
                        state_d = DIV_FIRST;
                        cnt_d   = DIV_LOAD;
                    end
                    if (load_use) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_flush = 1'b1;
                    div_busy    = 1'b1;
                    cnt_d       = cnt_q - DCW'(1);
                    if (cnt_q <= DCW'(1)) begin
                        state_d = DIV_LAST;
                    end
                end
                DIV_LAST: begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    idex_hold = 1'b1;
                    div_busy  = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and divide countdown.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ID/EX source copies follow the ID/EX register: bubble on flush, frozen on hold.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ex_rs1 <= REG_X0;
            ex_rs2 <= REG_X0;
        end else if (idex_flush) begin
            ex_rs1 <= REG_X0;
            ex_rs2 <= REG_X0;
        end else if (!idex_hold) begin
            ex_rs1 <= bus.id_rs1;
            ex_rs2 <= bus.id_rs2;
        end
    end

    // Performance counters: one stall per held-PC cycle, one flush per redirect cycle, free-running wrap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + CNT_W'(pc_hold);
            flush_q <= flush_q + CNT_W'(bus.mem_redirect);
        end
    end

    assign bus.pc_hold     = pc_hold;
    assign bus.ifid_hold   = ifid_hold;
    assign bus.idex_hold   = idex_hold;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.div_busy    = div_busy;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32 core (IF, ID, EX, MEM, WB). It issues per-stage hold/flush controls and operand-forwarding selects. It inserts load-use bubbles, holds the pipe for the multi-cycle divide path, and squashes younger stages on a taken branch or jump resolved in MEM. It also keeps stall and flush performance counters.

## Interface
- DIV_LATENCY, 8: EX cycles a DIV/DIVU/REM/REMU occupies (2..32)
- CNT_W, 32: performance counter width
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2
- ex_rd  in  5  destination of the ID/EX instruction
- ex_regwrite, ex_memtoreg  in  1 each  ID/EX write-enable and load flag
- ex_div  in  1  ID/EX holds a divide/remainder op
- mem_rd  in  5  destination in EX/MEM
- mem_regwrite, mem_memtoreg  in  1 each  EX/MEM write-enable and load flag
- wb_rd  in  5  destination in MEM/WB
- wb_regwrite  in  1  MEM/WB write-enable
- mem_redirect  in  1  taken branch or jump in MEM (Branch & branchCmp, or Jump)
- pc_hold, ifid_hold, idex_hold  out  1 each  register keeps its value this edge
- ifid_flush, idex_flush, exmem_flush  out  1 each  register loads a bubble (all controls 0)
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result
- div_busy  out  1  divide occupying EX
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Forwarding, combinational. Sources are evaluated for the ID/EX instruction's rs1 and rs2, which are registered internally from id_rs1/id_rs2 when ID/EX advances.
  - fwd=10 if mem_regwrite, !mem_memtoreg, mem_rd!=0 and mem_rd==rs.
  - Otherwise fwd=01 if wb_regwrite, wb_rd!=0 and wb_rd==rs.
  - Otherwise 00. EX/MEM always wins over MEM/WB.
  - x0 is never forwarded.
- Load-use stall: a load in EX with ex_rd!=0 whose ex_rd matches a used ID source.
  - pc_hold=ifid_hold=1 and idex_flush=1 for exactly one cycle.
  - A load in MEM matching EX is resolved by MEM/WB forwarding on the next cycle, so it never stalls.
- Divide FSM, states IDLE, DIV_WAIT, DIV_LAST.
  - IDLE→DIV_WAIT when ex_div=1 and mem_redirect=0; the counter loads DIV_LATENCY-2.
  - DIV_WAIT decrements and moves to DIV_LAST at 0. DIV_LAST→IDLE after one cycle.
  - In DIV_WAIT and DIV_LAST: pc_hold=ifid_hold=idex_hold=1 and div_busy=1.
  - exmem_flush=1 in DIV_WAIT only. In DIV_LAST the result enters EX/MEM.
  - A new ex_div seen in IDLE on the cycle after DIV_LAST is the next instruction and starts a fresh divide.
- Redirect has priority over everything else.
  - mem_redirect=1: ifid_flush=idex_flush=exmem_flush=1, all holds 0, and the FSM is forced to IDLE (the in-flight divide is aborted).
  - The PC takes the target on the same edge.
- Priority order: redirect > divide > load-use. A load-use condition during a divide is re-evaluated after DIV_LAST.
- Counters:
  - stall_cnt increments on every cycle with pc_hold=1.
  - flush_cnt increments once per mem_redirect cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset, asynchronous: FSM=IDLE, counter=0, all hold/flush=0, div_busy=0, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0, internal rs copies=0.
- Reset asserted mid-divide aborts it immediately. After release the FSM resumes in IDLE.
- Forwarding and hold/flush outputs are combinational from inputs and current state, valid in the same cycle.
- A divide holds ID and earlier stages for exactly DIV_LATENCY-1 cycles: DIV_LATENCY-2 in DIV_WAIT, 1 in DIV_LAST.
- Load-use costs 1 bubble. A redirect costs 3 squashed instructions.
- A hold and a flush on the same register never assert together. When the redirect wins, the hold deasserts.
- Counters update on the rising edge following the qualifying cycle.

## Structure
- Shared package core_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the FSM state enum (IDLE/DIV_WAIT/DIV_LAST)
  - REG_X0=5'd0
- One sub-module, forward_sel: pure combinational per-operand forwarding mux select. It is instantiated twice (rs1, rs2).
- Top level holds the FSM, the counter, the ID/EX rs copies and the performance counters.

## Test plan
- Back-to-back ADD x5 then ADD x6,x5,x5 → fwd_a=fwd_b=10 in the second instruction's EX cycle; with one NOP between them → 01; with rd=x0 → 00.
- LW x7 then ADD x8,x7,x1 → one cycle of pc_hold=ifid_hold=1 and idex_flush=1, then fwd_a=01; stall_cnt=1.
- DIV with DIV_LATENCY=8 → div_busy high 7 cycles, exmem_flush high 6 cycles, stall_cnt=7; the following instruction enters EX on cycle 8.
- Divide in EX with a taken BEQ in MEM on the second DIV_WAIT cycle → all three flushes, FSM=IDLE, div_busy=0 next cycle, flush_cnt=1.
- Load-use condition and mem_redirect in the same cycle → only flushes asserted, no holds, stall_cnt unchanged.
- RESET driven low mid-DIV_WAIT, then released → all outputs 0 immediately; first ex_div after release starts a full 7-cycle hold.
